// File: rtl/ex_stage.sv
`default_nettype none
// ex_stage: ID_EX capture, forwarding, operand select and ALU, registered into EX_MEM.
// Revision: 1.0
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ID_RegWrite,
  input  logic        ID_MemtoReg,
  input  logic        ID_MemRead,
  input  logic        ID_MemWrite,
  input  logic        ID_Link,
  input  logic        ID_ALUSrc1,
  input  logic        ID_ALUSrc2,
  input  logic [5:0]  ID_ALUFun,
  input  logic        ID_Sign,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic [4:0]  ID_WriteRegister,
  input  logic [31:0] ID_RsData,
  input  logic [31:0] ID_RtData,
  input  logic [31:0] ID_Imm,
  input  logic [4:0]  ID_Shamt,
  input  logic [31:0] ID_PC_plus4,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_WriteRegister,
  input  logic [31:0] WB_RegWriteData,
  output logic        EX_MemRead,
  output logic [4:0]  EX_WriteRegister,
  output logic        MEM_RegWrite,
  output logic        MEM_MemtoReg,
  output logic        MEM_MemRead,
  output logic        MEM_MemWrite,
  output logic [4:0]  MEM_WriteRegister,
  output logic [31:0] MEM_ALUResult,
  output logic [31:0] MEM_StoreData
);

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        link;
    logic        alu_src1;
    logic        alu_src2;
    logic [5:0]  alu_fun;
    logic        sign;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [31:0] pc4;
  } idex_t;

  idex_t       w_in;
  idex_t       r_ex;
  logic        w_mem_ok;
  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_alu;
  logic [31:0] w_res;

  assign w_in = '{reg_write: ID_RegWrite, mem_to_reg: ID_MemtoReg, mem_read: ID_MemRead,
                  mem_write: ID_MemWrite, link: ID_Link, alu_src1: ID_ALUSrc1,
                  alu_src2: ID_ALUSrc2, alu_fun: ID_ALUFun, sign: ID_Sign, rs: ID_Rs,
                  rt: ID_Rt, wr: ID_WriteRegister, rs_data: ID_RsData, rt_data: ID_RtData,
                  imm: ID_Imm, shamt: ID_Shamt, pc4: ID_PC_plus4};

  // A bubble clears data and indices too, so a flushed slot can never forward or write.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_ex <= '0;
    end else if (!stall) begin
      r_ex <= w_in;
    end
  end

  assign EX_MemRead       = r_ex.mem_read;
  assign EX_WriteRegister = r_ex.wr;

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] id_data,
                                      input logic mem_ok, input logic [4:0] mem_idx,
                                      input logic [31:0] mem_data, input logic wb_ok,
                                      input logic [4:0] wb_idx, input logic [31:0] wb_data);
    if (idx == 5'd0) return id_data;
    if (mem_ok && mem_idx == idx) return mem_data;
    if (wb_ok && wb_idx == idx) return wb_data;
    return id_data;
  endfunction

  // A load's MEM_ALUResult is an address, not the loaded value.
  assign w_mem_ok = MEM_RegWrite && !MEM_MemRead;
  assign w_fwd_rs = fwd(r_ex.rs, r_ex.rs_data, w_mem_ok, MEM_WriteRegister, MEM_ALUResult,
                        WB_RegWrite, WB_WriteRegister, WB_RegWriteData);
  assign w_fwd_rt = fwd(r_ex.rt, r_ex.rt_data, w_mem_ok, MEM_WriteRegister, MEM_ALUResult,
                        WB_RegWrite, WB_WriteRegister, WB_RegWriteData);

  assign w_a = r_ex.alu_src1 ? {27'b0, r_ex.shamt} : w_fwd_rs;
  assign w_b = r_ex.alu_src2 ? r_ex.imm : w_fwd_rt;

  always_comb begin
    w_alu = 32'd0;
    case (r_ex.alu_fun[5:4])
      2'b00: w_alu = r_ex.alu_fun[0] ? (w_a - w_b) : (w_a + w_b);
      2'b01: begin
        case (r_ex.alu_fun[3:0])
          4'b1000: w_alu = w_a & w_b;
          4'b1110: w_alu = w_a | w_b;
          4'b0110: w_alu = w_a ^ w_b;
          4'b0001: w_alu = ~(w_a | w_b);
          4'b1010: w_alu = w_a;
          default: w_alu = 32'd0;
        endcase
      end
      2'b10: begin
        case (r_ex.alu_fun[1:0])
          2'b00:   w_alu = w_b << w_a[4:0];
          2'b01:   w_alu = w_b >> w_a[4:0];
          2'b11:   w_alu = $unsigned($signed(w_b) >>> w_a[4:0]);
          default: w_alu = 32'd0;
        endcase
      end
      default: begin
        case (r_ex.alu_fun[3:1])
          3'b001:  w_alu = {31'b0, w_a == w_b};
          3'b000:  w_alu = {31'b0, w_a != w_b};
          3'b010:  w_alu = {31'b0, r_ex.sign ? ($signed(w_a) < $signed(w_b)) : (w_a < w_b)};
          3'b110:  w_alu = {31'b0, w_a[31] || (w_a == 32'd0)};
          3'b101:  w_alu = {31'b0, w_a[31]};
          3'b111:  w_alu = {31'b0, !w_a[31] && (w_a != 32'd0)};
          default: w_alu = 32'd0;
        endcase
      end
    endcase
  end

  assign w_res = r_ex.link ? r_ex.pc4 : w_alu;

  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_RegWrite      <= 1'b0;
      MEM_MemtoReg      <= 1'b0;
      MEM_MemRead       <= 1'b0;
      MEM_MemWrite      <= 1'b0;
      MEM_WriteRegister <= 5'd0;
      MEM_ALUResult     <= 32'd0;
      MEM_StoreData     <= 32'd0;
    end else begin
      MEM_RegWrite      <= r_ex.reg_write;
      MEM_MemtoReg      <= r_ex.mem_to_reg;
      MEM_MemRead       <= r_ex.mem_read;
      MEM_MemWrite      <= r_ex.mem_write;
      MEM_WriteRegister <= r_ex.wr;
      MEM_ALUResult     <= w_res;
      MEM_StoreData     <= w_fwd_rt;
    end
  end

endmodule
`default_nettype wire
